// File: rtl/crc_checker.sv
// ---------------------------------------------------------------------------
// crc_checker
//   Serial CRC receiver/checker, the far-end counterpart of the serial CRC
//   generator on the receive side of the LPCS link. Payload bits are folded
//   into an LFSR while Active=1. Once Active drops, CRC_W transmitted CRC bits
//   (LSB first, qualified by Valid) are compared against the frozen LFSR.
//   A one-cycle Done strobe then reports the verdict on Match/Error, which
//   hold until the next Done.
//
// Ports
//   CLK        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   DATA       in   1  serial line: payload bit or CRC bit
//   Active     in   1  DATA carries a payload bit (wins over Valid)
//   Valid      in   1  DATA carries a CRC bit (ignored while Active=1)
//   Done       out  1  one-cycle pulse: frame check complete
//   Match      out  1  received CRC equals computed CRC (held)
//   Error      out  1  mismatch or protocol abort (held)
//   Err_Count  out  8  saturating failed-frame count (CRC_ERR_CNT_EN only)
//
// Configuration macro
//   CRC_ERR_CNT_EN : when defined, adds the Err_Count port and counter.
// ---------------------------------------------------------------------------
module crc_checker #(
    parameter int unsigned      CRC_W = 8,
    parameter logic [CRC_W-1:0] SEED  = 8'hD8,
    parameter logic [CRC_W-1:0] TAPS  = 8'h44
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       DATA,
    input  logic       Active,
    input  logic       Valid,
    output logic       Done,
    output logic       Match,
`ifdef CRC_ERR_CNT_EN
    output logic       Error,
    output logic [7:0] Err_Count
`else
    output logic       Error
`endif
);

    localparam int unsigned    CNT_W    = $clog2(CRC_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CRC_W - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // One LFSR step: feedback enters at the MSB and is XORed into tapped bits.
    function automatic logic [CRC_W-1:0] lfsr_step(input logic [CRC_W-1:0] cur,
                                                   input logic             din);
        logic             fb;
        logic [CRC_W-1:0] nxt;
        fb  = din ^ cur[0];
        nxt = (cur >> 1) ^ (TAPS & {CRC_W{fb}});
        nxt[CRC_W-1] = fb;
        return nxt;
    endfunction

    logic [1:0]       state_r, state_s;
    logic [CRC_W-1:0] lfsr_r, lfsr_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             mis_r, mis_s;
    logic             done_r, done_s;
    logic             match_r, match_s;
    logic             error_r, error_s;
    logic             start_s;
    logic             take_crc_s;
    logic             take_last_s;
    logic             abort_s;

    // Next-state, LFSR, CRC comparison and frame verdict.
    always_comb begin
        state_s     = state_r;
        lfsr_s      = lfsr_r;
        cnt_s       = cnt_r;
        mis_s       = mis_r;
        done_s      = 1'b0;
        match_s     = match_r;
        error_s     = error_r;
        start_s     = 1'b0;
        take_crc_s  = 1'b0;
        take_last_s = 1'b0;
        abort_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // IDLE always holds LFSR=SEED, cnt=0, mis=0, so a Valid bit
                // here is CRC bit 0 of a zero-length frame.
                if (Active) begin
                    start_s = 1'b1;
                end else begin
                    take_crc_s = Valid;
                end
            end
            ST_DATA: begin
                if (Active) begin
                    lfsr_s = lfsr_step(lfsr_r, DATA);
                end else begin
                    state_s    = ST_CHECK;
                    take_crc_s = Valid;
                end
            end
            ST_CHECK: begin
                if (Active) begin
                    start_s = 1'b1;
                    abort_s = 1'b1;
                end else begin
                    take_crc_s = Valid;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                lfsr_s  = SEED;
                cnt_s   = {CNT_W{1'b0}};
                mis_s   = 1'b0;
                start_s = Active;
            end
            default: begin
                state_s = ST_IDLE;
                lfsr_s  = SEED;
                cnt_s   = {CNT_W{1'b0}};
                mis_s   = 1'b0;
            end
        endcase

        // A new frame always restarts from SEED with DATA as payload bit 0.
        if (start_s) begin
            lfsr_s  = lfsr_step(SEED, DATA);
            cnt_s   = {CNT_W{1'b0}};
            mis_s   = 1'b0;
            state_s = ST_DATA;
        end else if (take_crc_s) begin
            lfsr_s      = lfsr_r >> 1;
            cnt_s       = cnt_r + CNT_W'(1);
            mis_s       = mis_r | (DATA ^ lfsr_r[0]);
            take_last_s = (cnt_r == LAST_CNT);
            if (cnt_r == LAST_CNT) begin
                state_s = ST_DONE;
            end else begin
                state_s = ST_CHECK;
            end
        end else begin
            take_last_s = 1'b0;
        end

        if (abort_s) begin
            done_s  = 1'b1;
            match_s = 1'b0;
            error_s = 1'b1;
        end else if (take_last_s) begin
            done_s  = 1'b1;
            match_s = ~mis_s;
            error_s = mis_s;
        end else begin
            done_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            lfsr_r  <= SEED;
            cnt_r   <= {CNT_W{1'b0}};
            mis_r   <= 1'b0;
            done_r  <= 1'b0;
            match_r <= 1'b0;
            error_r <= 1'b0;
        end else begin
            state_r <= state_s;
            lfsr_r  <= lfsr_s;
            cnt_r   <= cnt_s;
            mis_r   <= mis_s;
            done_r  <= done_s;
            match_r <= match_s;
            error_r <= error_s;
        end
    end

    assign Done  = done_r;
    assign Match = match_r;
    assign Error = error_r;

`ifdef CRC_ERR_CNT_EN
    logic [7:0] err_cnt_r, err_cnt_s;

    // Saturating failed-frame counter, advanced on each erroneous verdict.
    always_comb begin
        err_cnt_s = err_cnt_r;
        if (done_s && error_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_s = err_cnt_r + 8'd1;
        end else begin
            err_cnt_s = err_cnt_r;
        end
    end

    // Failed-frame counter register, cleared only by reset.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= 8'd0;
        end else begin
            err_cnt_r <= err_cnt_s;
        end
    end

    assign Err_Count = err_cnt_r;
`endif

endmodule

// File: tb/tb_crc_checker.sv
// ---------------------------------------------------------------------------
// tb_crc_checker
//   Self-checking bench for crc_checker. A frame-level reference model keeps
//   the received payload as a bit queue, computes its CRC from scratch when
//   the CRC field completes, and predicts Done/Match/Error/Err_Count after
//   every clock edge. Directed frames plus randomized traffic.
// ---------------------------------------------------------------------------
module tb_crc_checker;

    logic       CLK;
    logic       rst_n;
    logic       DATA;
    logic       Active;
    logic       Valid;
    logic       Done;
    logic       Match;
    logic       Error;
`ifdef CRC_ERR_CNT_EN
    logic [7:0] Err_Count;
`endif

    crc_checker dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .DATA      (DATA),
        .Active    (Active),
        .Valid     (Valid),
        .Done      (Done),
        .Match     (Match),
`ifdef CRC_ERR_CNT_EN
        .Error     (Error),
        .Err_Count (Err_Count)
`else
        .Error     (Error)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_pass;
    int n_total;

    localparam int PH_IDLE = 0;
    localparam int PH_PAY  = 1;
    localparam int PH_CRC  = 2;
    localparam int PH_DONE = 3;

    // Reference model state
    int         ph;
    bit         pay[$];
    logic [7:0] rx;
    int         rxn;
    bit         e_done;
    bit         e_match;
    bit         e_err;
    int         e_cnt;

    // CRC of a whole payload, straight from the LFSR rule starting at SEED.
    function automatic logic [7:0] crc_of(input bit q[$]);
        logic [7:0] r;
        logic       fb;
        r = 8'hD8;
        foreach (q[i]) begin
            fb   = q[i] ^ r[0];
            r    = (r >> 1) ^ (fb ? 8'h44 : 8'h00);
            r[7] = fb;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph      = PH_IDLE;
        pay.delete();
        rx      = 8'h00;
        rxn     = 0;
        e_done  = 1'b0;
        e_match = 1'b0;
        e_err   = 1'b0;
        e_cnt   = 0;
    endtask

    task automatic finish_frame(input bit err);
        e_done  = 1'b1;
        e_err   = err;
        e_match = !err;
        if (err && e_cnt < 255) e_cnt++;
    endtask

    // Predict the outputs that follow the clock edge sampling these inputs.
    task automatic model_step(input bit a, input bit v, input bit d);
        e_done = 1'b0;
        if (a) begin
            if (ph == PH_CRC) finish_frame(1'b1);
            if (ph != PH_PAY) pay.delete();
            pay.push_back(d);
            ph = PH_PAY;
        end else if (ph == PH_DONE) begin
            ph = PH_IDLE;
        end else if (ph == PH_IDLE && !v) begin
            ph = PH_IDLE;
        end else begin
            if (ph == PH_IDLE) pay.delete();
            if (ph != PH_CRC) begin
                rx  = 8'h00;
                rxn = 0;
                ph  = PH_CRC;
            end
            if (v) begin
                rx[rxn] = d;
                rxn++;
                if (rxn == 8) begin
                    finish_frame(rx != crc_of(pay));
                    ph = PH_DONE;
                    pay.delete();
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("done",  Done,  e_done);
        check("match", Match, e_match);
        check("error", Error, e_err);
`ifdef CRC_ERR_CNT_EN
        check("err_count", Err_Count, 8'(e_cnt));
`endif
    endtask

    // One cycle: drive inputs, advance model, compare after the edge.
    task automatic step(input bit a, input bit v, input bit d);
        Active = a;
        Valid  = v;
        DATA   = d;
        model_step(a, v, d);
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    // Payload bits; Valid toggles randomly to exercise Active priority.
    task automatic send_payload(input bit q[$]);
        foreach (q[i]) step(1'b1, 1'($urandom_range(0, 1)), q[i]);
    endtask

    // First n CRC bits LSB first, with a gap of gap_len cycles before bit gap_at.
    task automatic send_crc(input logic [7:0] c, input int n, input int gap_at, input int gap_len);
        logic [7:0] cv;
        cv = c;
        for (int k = 0; k < n; k++) begin
            if (k == gap_at) idle(gap_len);
            step(1'b0, 1'b1, cv[k]);
        end
    endtask

    task automatic rand_payload(output bit q[$], input int len);
        q.delete();
        repeat (len) q.push_back(1'($urandom_range(0, 1)));
    endtask

    bit         p[$];
    bit         p2[$];
    logic [7:0] c;
    bit         match_gapless;
    int         len;

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        DATA    = 1'b0;
        Active  = 1'b0;
        Valid   = 1'b0;
        model_reset();

        // Model pinned by hand-computed values
        p.delete();
        check("model_crc_empty", crc_of(p), 8'hD8);
        p.push_back(1'b0);
        check("model_crc_0", crc_of(p), 8'h6C);
        p.delete();
        p.push_back(1'b1);
        check("model_crc_1", crc_of(p), 8'hA8);

        // 1. Reset held for 3 cycles
        repeat (3) begin
            @(posedge CLK);
            #1;
            check_outputs();
        end
        check("reset_done", Done, 1'b0);
        rst_n = 1'b1;
        idle(2);

        // 2. Zero-length frame: CRC equals SEED
        send_crc(8'hD8, 8, -1, 0);
        check("t2_done", Done, 1'b1);
        check("t2_match", Match, 1'b1);
        check("t2_error", Error, 1'b0);
        idle(2);

        // 3. Single-bit payloads
        p.delete();
        p.push_back(1'b0);
        send_payload(p);
        send_crc(8'h6C, 8, -1, 0);
        check("t3_match0", Match, 1'b1);
        idle(1);
        p.delete();
        p.push_back(1'b1);
        send_payload(p);
        send_crc(8'hA8, 8, -1, 0);
        check("t3_match1", Match, 1'b1);
        idle(1);

        // 4. 16 random bits with one flipped CRC bit, then a good frame
        rand_payload(p, 16);
        c = crc_of(p) ^ (8'h01 << $urandom_range(0, 7));
        send_payload(p);
        send_crc(c, 8, -1, 0);
        check("t4_error", Error, 1'b1);
        check("t4_match", Match, 1'b0);
`ifdef CRC_ERR_CNT_EN
        check("t4_cnt1", Err_Count, 8'd1);
`endif
        idle(1);
        rand_payload(p, 16);
        send_payload(p);
        send_crc(crc_of(p), 8, -1, 0);
        check("t4_good", Match, 1'b1);
`ifdef CRC_ERR_CNT_EN
        check("t4_cnt_hold", Err_Count, 8'd1);
`endif
        idle(1);

        // 5. Gap of 5 cycles between CRC bits 3 and 4
        rand_payload(p, 10);
        c = crc_of(p);
        send_payload(p);
        send_crc(c, 8, -1, 0);
        match_gapless = Match;
        idle(1);
        send_payload(p);
        send_crc(c, 8, 4, 5);
        check("t5_done_timing", Done, 1'b1);
        check("t5_same", Match, match_gapless);
        idle(1);

        // 6. Abort after 4 CRC bits; the aborting bit starts the next frame
        rand_payload(p, 6);
        send_payload(p);
        send_crc(crc_of(p), 4, -1, 0);
        rand_payload(p2, 9);
        step(1'b1, 1'b0, p2[0]);
        check("t6_abort_done", Done, 1'b1);
        check("t6_abort_err", Error, 1'b1);
        for (int i = 1; i < 9; i++) step(1'b1, 1'b0, p2[i]);
        send_crc(crc_of(p2), 8, -1, 0);
        check("t6_new_match", Match, 1'b1);
        idle(1);

        // Randomized frames: varying lengths, gaps, flips, aborts, back-to-back
        for (int f = 0; f < 60; f++) begin
            len = $urandom_range(0, 20);
            rand_payload(p, len);
            c = crc_of(p);
            if ($urandom_range(0, 3) == 0) c = c ^ (8'h01 << $urandom_range(0, 7));
            if (len == 0) idle($urandom_range(1, 3));
            else idle($urandom_range(0, 2));
            send_payload(p);
            if ($urandom_range(0, 5) == 0) begin
                send_crc(c, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
            end else begin
                send_crc(c, 8, $urandom_range(0, 9), $urandom_range(0, 4));
            end
        end
        idle(2);

        // Raw random line activity
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(3);

        // Mid-frame reset: frame discarded, outputs cleared, no Done
        rand_payload(p, 8);
        send_payload(p);
        send_crc(crc_of(p), 3, -1, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_done", Done, 1'b0);
        check("midrst_match", Match, 1'b0);
        check("midrst_error", Error, 1'b0);
        model_reset();
        Active = 1'b0;
        Valid  = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            #1;
            check_outputs();
        end
        rst_n = 1'b1;
        idle(4);
        rand_payload(p, 5);
        send_payload(p);
        send_crc(crc_of(p), 8, -1, 0);
        check("post_rst_match", Match, 1'b1);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
